mod_updown_counter: RTL and testbench

//   Parametrised synchronous successor to the 4-bit ripple up-counter.

---
 rtl/mod_updown_counter.sv | 70 +++++++
 tb/tb_mod_updown_counter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mod_updown_counter.sv
// Modulo-MODULUS up/down counter with enable, synchronous clear, clamped parallel load,
// optional saturation, combinational terminal count and registered wrap/sat flags.
module mod_updown_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 16,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] One    = WIDTH'(1);

    logic [WIDTH-1:0] q_next;
    logic             wrap_next;
    logic             sat_next;
    logic             at_end;

    always_comb begin
        at_end    = up_dn ? (q == MaxVal) : (q == '0);
        tc        = en & ~clr & ~load & at_end;
        wrap_next = tc & ~SATURATE;
        q_next    = q;
        sat_next  = sat;

        if (clr) begin
            q_next   = '0;
            sat_next = 1'b0;
        end else if (load) begin
            // Out-of-range loads clamp so a non-power-of-2 range never holds an illegal value.
            q_next   = (load_val > MaxVal) ? MaxVal : load_val;
            sat_next = 1'b0;
        end else if (en) begin
            if (at_end) begin
                if (SATURATE) begin
                    q_next = q;
                end else begin
                    q_next = up_dn ? '0 : MaxVal;
                end
                sat_next = SATURATE;
            end else begin
                q_next   = up_dn ? (q + One) : (q - One);
                sat_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= '0;
            wrap <= 1'b0;
            sat  <= 1'b0;
        end else begin
            q    <= q_next;
            wrap <= wrap_next;
            sat  <= sat_next;
        end
    end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench: wrapping, saturating and two-digit cascaded counters against an
// integer reference model; a negedge monitor pops expectations and compares.
module tb_mod_updown_counter;

    localparam int M = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, up_dn = 1'b1, clr = 1'b0, load = 1'b0, en_c = 1'b0;
    logic [3:0] load_val = '0;

    logic [3:0] w_q, s_q, lo_q, hi_q;
    logic       w_tc, w_wrap, w_sat, s_tc, s_wrap, s_sat;
    logic       lo_tc, lo_wrap, lo_sat, hi_tc, hi_wrap, hi_sat;

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(4), .MODULUS(M), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .q(w_q), .tc(w_tc), .wrap(w_wrap), .sat(w_sat)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(M), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .q(s_q), .tc(s_tc), .wrap(s_wrap), .sat(s_sat)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(M), .SATURATE(1'b0)) u_lo (
        .clk(clk), .rst(rst), .en(en_c), .up_dn(up_dn), .clr(clr), .load(1'b0),
        .load_val(4'd0), .q(lo_q), .tc(lo_tc), .wrap(lo_wrap), .sat(lo_sat)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(M), .SATURATE(1'b0)) u_hi (
        .clk(clk), .rst(rst), .en(lo_tc), .up_dn(up_dn), .clr(clr), .load(1'b0),
        .load_val(4'd0), .q(hi_q), .tc(hi_tc), .wrap(hi_wrap), .sat(hi_sat)
    );

    typedef struct {
        int wq, wtc, wwrap;
        int sq, stc, ssat;
        int lq, hq, ltc, htc, lwrap, hwrap;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Reference state: plain integers, updated by the arithmetic rules of the counter.
    int mw = 0, mw_wrap = 0;
    int ms = 0, ms_sat = 0;
    int mc = 0, mc_lwrap = 0, mc_hwrap = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int clamp(int v);
        return (v > M - 1) ? M - 1 : v;
    endfunction

    task automatic drive(input logic e, input logic u, input logic c, input logic l,
                         input logic [3:0] lv, input logic ec);
        exp_t x;
        int   nxt, dir;
        @(posedge clk);
        #1;
        en = e; up_dn = u; clr = c; load = l; load_val = lv; en_c = ec;
        dir = u ? 1 : -1;

        x.wq = mw; x.wwrap = mw_wrap;
        x.wtc = int'(e && !c && !l && (u ? (mw == M - 1) : (mw == 0)));
        x.sq = ms; x.ssat = ms_sat;
        x.stc = int'(e && !c && !l && (u ? (ms == M - 1) : (ms == 0)));
        x.lq = mc % 10; x.hq = mc / 10;
        x.lwrap = mc_lwrap; x.hwrap = mc_hwrap;
        x.ltc = int'(ec && !c && (u ? (mc % 10 == 9) : (mc % 10 == 0)));
        x.htc = int'(x.ltc != 0 && (u ? (mc / 10 == 9) : (mc / 10 == 0)));
        sb.push_back(x);

        // Wrapping counter
        if (c) mw = 0;
        else if (l) mw = clamp(int'(lv));
        else if (e) mw = (mw + dir + M) % M;
        mw_wrap = x.wtc;

        // Saturating counter: a blocked step pins it at the end and raises sat
        if (c) begin ms = 0; ms_sat = 0; end
        else if (l) begin ms = clamp(int'(lv)); ms_sat = 0; end
        else if (e) begin
            nxt = ms + dir;
            if (nxt < 0 || nxt > M - 1) ms_sat = 1;
            else begin ms = nxt; ms_sat = 0; end
        end

        // Cascaded pair behaves as one decimal counter 0..99
        if (c) mc = 0;
        else if (ec) mc = (mc + dir + 100) % 100;
        mc_lwrap = x.ltc;
        mc_hwrap = x.htc;
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        en = 1'b0; clr = 1'b0; load = 1'b0; en_c = 1'b0;
        #1;
        chk("rst_w_q", int'(w_q), 0);
        chk("rst_w_wrap", int'(w_wrap), 0);
        chk("rst_s_q", int'(s_q), 0);
        chk("rst_s_sat", int'(s_sat), 0);
        chk("rst_lo_q", int'(lo_q), 0);
        chk("rst_hi_q", int'(hi_q), 0);
        #1;
        rst = 1'b0;
        mw = 0; mw_wrap = 0; ms = 0; ms_sat = 0;
        mc = 0; mc_lwrap = 0; mc_hwrap = 0;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("w_q", int'(w_q), x.wq);
                chk("w_tc", int'(w_tc), x.wtc);
                chk("w_wrap", int'(w_wrap), x.wwrap);
                chk("w_sat", int'(w_sat), 0);
                chk("s_q", int'(s_q), x.sq);
                chk("s_tc", int'(s_tc), x.stc);
                chk("s_wrap", int'(s_wrap), 0);
                chk("s_sat", int'(s_sat), x.ssat);
                chk("lo_q", int'(lo_q), x.lq);
                chk("hi_q", int'(hi_q), x.hq);
                chk("lo_tc", int'(lo_tc), x.ltc);
                chk("hi_tc", int'(hi_tc), x.htc);
                chk("lo_wrap", int'(lo_wrap), x.lwrap);
                chk("hi_wrap", int'(hi_wrap), x.hwrap);
                chk("lo_sat", int'(lo_sat), 0);
                chk("hi_sat", int'(hi_sat), 0);
            end
        end
    end

    initial begin : stimulus
        repeat (2) @(posedge clk);
        #4;
        rst = 1'b0;

        // Reset mid-count at 9, then count up from 0
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        async_reset();
        repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);

        // Up wrap from 0 through 9 back to 0
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        repeat (12) drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);

        // Down wrap from 0
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        repeat (12) drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

        // Saturation: climb past 9, then step down
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd7, 1'b0);
        repeat (5) drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

        // Priority: clr over load over en, then clamped load, then hold
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd12, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd15, 1'b0);

        // Cascade: full 00..99 cycle and past the rollover, then down through 00
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        repeat (205) drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        repeat (15) drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 9) == 0),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
        end

        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
